mips_register_file: RTL and testbench
=====================================

MIPS_REGISTER_FILE -- requirements
Module: mips_register_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, the register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, the register address width; register count is 2**ADDR_W (32).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Port read_reg1, input, ADDR_W: read port 1 address (instruction rs field).
REQ-007 Port read_reg2, input, ADDR_W: read port 2 address (instruction rt field).
REQ-008 Port write_reg, input, ADDR_W: write address, driven by the RegDst 5-bit destination mux output (rt or rd).
REQ-009 Port write_data, input, DATA_W: write data (ALU result or memory load data).
REQ-010 Port reg_write, input, 1: write enable (RegWrite control).
REQ-011 Port read_data1, output, DATA_W: contents of register read_reg1.
REQ-012 Port read_data2, output, DATA_W: contents of register read_reg2.

Function
REQ-013 Storage SHALL be 2**ADDR_W registers of DATA_W bits each, R0..R31.
REQ-014 Read ports SHALL be combinational: read_dataN reflects the addressed register with no clock latency.
REQ-015 A write SHALL occur on the rising clk edge only when reg_write=1 and rst=0; write_data is stored into R[write_reg].
REQ-016 R0 SHALL be hardwired to zero: writes to address 0 are discarded, and reads of address 0 return 0 regardless of history.
REQ-017 With reg_write=0, no register SHALL change on any clock edge.
REQ-018 A same-cycle read of the register being written SHALL return the old value until the edge; the new value is visible combinationally immediately after the edge (no internal bypass).
REQ-019 Both read ports addressing the same register SHALL return identical data.
REQ-020 write_reg, write_data and reg_write SHALL be sampled only at the rising edge; glitches between edges have no effect.
REQ-021 Exactly one register SHALL be written per enabled edge, selected by a 5-to-32 one-hot decode of write_reg gated by reg_write.

Reset
REQ-022 Asserting rst SHALL immediately clear R0..R31 to 0, independent of clk.
REQ-023 While rst=1, read_data1 and read_data2 SHALL be 0 and clock edges SHALL not write.
REQ-024 Reset asserted mid-operation, including at a write edge, SHALL win: the written register reads 0 after reset.
REQ-025 The first write SHALL take effect on the first rising clk edge after rst deasserts.

Structure
REQ-026 DATA_W, ADDR_W, REG_COUNT and the zero-register index SHALL be constants in the shared package mips_pkg.
REQ-027 The storage element SHALL be one sub-module, register_32bit: DATA_W-bit register with clk, rst, enable, d and q; instantiated 31 times for R1..R31.
REQ-028 Read selection SHALL be built from 32-to-1 DATA_W-bit multiplexing; write enables from a 5-to-32 decoder ANDed with reg_write.

Verification
REQ-029 Reset: rst=1 after random prior writes -> read_data1/2 = 0 for every address 0..31.
REQ-030 Write/read: reg_write=1, write_reg=8, write_data=0x0000_00FF, one edge -> read_reg1=8 gives 0x0000_00FF; read_reg2=9 gives 0.
REQ-031 Zero register: reg_write=1, write_reg=0, write_data=0xDEAD_BEEF, one edge -> read of address 0 returns 0x0000_0000.
REQ-032 Disabled write: R5=0x1234_5678, then reg_write=0, write_reg=5, write_data=0xFFFF_FFFF, edge -> R5 stays 0x1234_5678.
REQ-033 Same-cycle read/write: R10=0x11, write 0x22 to R10 with read_reg1=10 -> before edge 0x11, after edge 0x22; read_reg2=10 matches.
REQ-034 Reset mid-write: rst pulses between edges while writing 0xAAAA_AAAA to R31 -> R31 reads 0 during and after reset until the next enabled edge.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared constants for the MIPS datapath register file.
//   DATA_W    : register width in bits
//   ADDR_W    : register address width
//   REG_COUNT : number of architectural registers (2**ADDR_W)
//   ZERO_REG  : index of the hardwired-zero register
package mips_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int REG_COUNT = 2 ** ADDR_W;
  localparam int ZERO_REG  = 0;

endpackage

// File: rtl/register_32bit.sv
// register_32bit
// Single general-purpose register with load enable and async clear.
// Ports:
//   clk    : clock, loads on rising edge
//   rst    : asynchronous active-high clear
//   enable : load d on the next rising edge
//   d      : load data
//   q      : stored value
module register_32bit #(
  parameter int DATA_W = mips_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (enable) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mips_register_file.sv
// mips_register_file
// 32 x DATA_W MIPS register file: two combinational read ports, one
// synchronous write port, R0 hardwired to zero, async active-high clear.
// Ports:
//   clk         : clock, writes on rising edge
//   rst         : asynchronous active-high reset, clears R1..R31
//   read_reg1   : read port 1 address (rs)
//   read_reg2   : read port 2 address (rt)
//   write_reg   : write address (RegDst mux output)
//   write_data  : write data
//   reg_write   : write enable
//   read_data1  : R[read_reg1]
//   read_data2  : R[read_reg2]
module mips_register_file #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  import mips_pkg::*;

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] reg_q [NREG];
  logic [NREG-1:1]   wr_en_d;

  // One-hot decode of write_reg gated by reg_write. Bit 0 is never
  // generated, so writes to R0 simply have nowhere to land.
  always_comb begin
    wr_en_d = '0;
    for (int i = 1; i < NREG; i++) begin
      wr_en_d[i] = reg_write && (write_reg == ADDR_W'(i));
    end
  end

  assign reg_q[ZERO_REG] = '0;

  for (genvar g = 1; g < NREG; g++) begin : g_reg
    register_32bit #(
      .DATA_W (DATA_W)
    ) u_reg (
      .clk    (clk),
      .rst    (rst),
      .enable (wr_en_d[g]),
      .d      (write_data),
      .q      (reg_q[g])
    );
  end

  // Plain read muxes, no write bypass: a same-cycle write shows up only
  // after the edge.
  assign read_data1 = reg_q[read_reg1];
  assign read_data2 = reg_q[read_reg2];

endmodule

// File: tb/tb_mips_register_file.sv
module tb_mips_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] read_data1, read_data2;

  int n_checks = 0;
  int n_errors = 0;

  // reference: plain array of architectural register values
  logic [31:0] model [32];

  mips_register_file dut (
    .clk        (clk),
    .rst        (rst),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Edge: update model from the architectural rule, then return at negedge.
  task automatic tick();
    @(posedge clk);
    if (!rst && reg_write && write_reg != 5'd0) model[write_reg] = write_data;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    write_reg = a; write_data = d; reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic check_both(input string tag);
    #1;
    chk({tag, "_rd1"}, read_data1, model[read_reg1]);
    chk({tag, "_rd2"}, read_data2, model[read_reg2]);
  endtask

  initial begin
    rst = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;

    // random prior writes, then reset must clear everything
    for (int i = 0; i < 40; i++) wr(5'($urandom_range(0, 31)), $urandom);
    rst = 1'b1;
    #1;
    clear_model();
    write_reg = 5'd7; write_data = 32'hCAFE_F00D; reg_write = 1'b1;
    tick();  // edge during reset must not write
    for (int a = 0; a < 32; a++) begin
      read_reg1 = 5'(a); read_reg2 = 5'(31 - a);
      #1;
      chk("rst_rd1", read_data1, 32'h0);
      chk("rst_rd2", read_data2, 32'h0);
    end
    reg_write = 1'b0;
    rst = 1'b0;
    #1;

    // first edge after reset writes
    read_reg1 = 5'd8; read_reg2 = 5'd9;
    wr(5'd8, 32'h0000_00FF);
    chk("wr8_rd1", read_data1, 32'h0000_00FF);
    chk("wr8_rd2_r9", read_data2, 32'h0);

    // zero register
    wr(5'd0, 32'hDEAD_BEEF);
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    #1;
    chk("r0_rd1", read_data1, 32'h0);
    chk("r0_rd2", read_data2, 32'h0);

    // disabled write
    wr(5'd5, 32'h1234_5678);
    write_reg = 5'd5; write_data = 32'hFFFF_FFFF; reg_write = 1'b0;
    tick();
    read_reg1 = 5'd5;
    #1;
    chk("nowr_r5", read_data1, 32'h1234_5678);

    // glitches between edges settle to disabled before the edge
    write_reg = 5'd5; write_data = 32'h0BAD_0BAD; reg_write = 1'b1;
    #2 reg_write = 1'b0; write_data = 32'h5555_5555;
    tick();
    #1;
    chk("glitch_r5", read_data1, 32'h1234_5678);

    // same-cycle read/write, no bypass
    wr(5'd10, 32'h11);
    read_reg1 = 5'd10; read_reg2 = 5'd10;
    write_reg = 5'd10; write_data = 32'h22; reg_write = 1'b1;
    #1;
    chk("rw_before", read_data1, 32'h11);
    tick();
    reg_write = 1'b0;
    chk("rw_after", read_data1, 32'h22);
    chk("rw_port2", read_data2, read_data1 === 32'h22 ? 32'h22 : 32'hx);

    // reset pulse between edges while a write to R31 is pending
    wr(5'd31, 32'h7777_0001);
    read_reg1 = 5'd31; read_reg2 = 5'd31;
    write_reg = 5'd31; write_data = 32'hAAAA_AAAA; reg_write = 1'b1;
    #1 rst = 1'b1;
    #1;
    clear_model();
    chk("midrst_during", read_data1, 32'h0);
    #1 rst = 1'b0;
    #1;
    chk("midrst_after", read_data2, 32'h0);
    tick();
    chk("midrst_nextedge", read_data1, 32'hAAAA_AAAA);
    reg_write = 1'b0;

    // reset asserted right at a write edge must win
    write_reg = 5'd12; write_data = 32'h1357_9BDF; reg_write = 1'b1;
    @(posedge clk);
    rst = 1'b1;
    #1;
    clear_model();
    @(negedge clk);
    rst = 1'b0; reg_write = 1'b0;
    read_reg1 = 5'd12; read_reg2 = 5'd31;
    check_both("rst_at_edge");

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom;
      reg_write  = ($urandom_range(0, 3) != 0);
      read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
      read_reg2  = ($urandom_range(0, 7) == 0) ? read_reg1 : 5'($urandom_range(0, 31));
      check_both("rnd_pre");
      tick();
      reg_write = 1'b0;
      check_both("rnd_post");
      if (i % 97 == 96) begin
        rst = 1'b1;
        #1;
        clear_model();
        check_both("rnd_rst");
        rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
